// File: rtl/dsp_div_pkg.sv
// Shared types and default widths for the sequential signed divider.
package dsp_div_pkg;

  localparam int DIVIDEND_W_DEF = 38;
  localparam int DIVISOR_W_DEF  = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/dsp_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module dsp_div_step #(
  parameter int DIVISOR_W = 18
) (
  input  logic [DIVISOR_W:0] rem_in,
  input  logic               bit_in,
  input  logic [DIVISOR_W:0] dmag,
  output logic [DIVISOR_W:0] rem_out,
  output logic               q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;

  // The remainder stays below the divisor magnitude, so the top bit of diff is a clean borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dmag};
    q_bit   = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/dsp_div_signed_seq.sv
// Sequential signed restoring divider, one quotient bit per falling clock edge,
// with truncation toward zero and divide-by-zero / overflow flags.
module dsp_div_signed_seq
  import dsp_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  // Handshake: operands transfer on a falling edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and out_valid is a one-cycle pulse with results held afterwards.
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W:0]   mag_q, mag_d;
  logic [DIVISOR_W:0]    dmag_q, dmag_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  div_by_zero_q, div_by_zero_d;
  logic                  overflow_q, overflow_d;

  logic [DIVIDEND_W:0]   a_ext, abs_a;
  logic [DIVISOR_W:0]    b_ext, abs_b;
  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] qmag;
  logic [DIVISOR_W-1:0]  rmag;
  logic                  unused_bits;

  dsp_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (mag_q[DIVIDEND_W-1]),
    .dmag    (dmag_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // One extra bit so |-2^(W-1)| is representable.
  always_comb begin
    a_ext = {dividend[DIVIDEND_W-1], dividend};
    b_ext = {divisor[DIVISOR_W-1], divisor};
    abs_a = a_ext[DIVIDEND_W] ? -a_ext : a_ext;
    abs_b = b_ext[DIVISOR_W] ? -b_ext : b_ext;
    qmag  = mag_q[DIVIDEND_W-1:0];
    rmag  = rem_q[DIVISOR_W-1:0];
  end

  // Bits that are provably zero or shifted out once the divide finishes.
  assign unused_bits = ^{mag_q[DIVIDEND_W], rem_q[DIVISOR_W]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mag_d         = mag_q;
    dmag_d        = dmag_q;
    rem_d         = rem_q;
    sign_a_d      = sign_a_q;
    sign_b_d      = sign_b_q;
    zero_d        = zero_q;
    ovf_d         = ovf_q;
    out_valid_d   = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d    = abs_a;
          dmag_d   = abs_b;
          sign_a_d = dividend[DIVIDEND_W-1];
          sign_b_d = divisor[DIVISOR_W-1];
          zero_d   = (divisor == '0);
          ovf_d    = (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor == '1);
          rem_d    = '0;
          cnt_d    = CNT_W'(DIVIDEND_W - 1);
          state_d  = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        mag_d = {mag_q[DIVIDEND_W-1:0], step_q};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        out_valid_d   = 1'b1;
        div_by_zero_d = zero_q;
        overflow_d    = ovf_q;
        if (zero_q) begin
          quotient_d  = '0;
          remainder_d = '0;
        end else begin
          // The overflow case falls out naturally: 2^(W-1) wraps to -2^(W-1).
          quotient_d  = (sign_a_q ^ sign_b_q) ? -qmag : qmag;
          remainder_d = sign_a_q ? -rmag : rmag;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mag_q         <= '0;
      dmag_q        <= '0;
      rem_q         <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mag_q         <= mag_d;
      dmag_q        <= dmag_d;
      rem_q         <= rem_d;
      sign_a_q      <= sign_a_d;
      sign_b_q      <= sign_b_d;
      zero_q        <= zero_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= out_valid_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_dsp_div_signed_seq.sv
// Directed and random checks of the sequential signed divider against hand values and / %.
module tb_dsp_div_signed_seq;

  localparam int AW = 38;
  localparam int BW = 18;
  localparam int LAT = AW + 1;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] dividend;
  logic signed [BW-1:0] divisor;
  logic                 out_valid;
  logic signed [AW-1:0] quotient;
  logic signed [BW-1:0] remainder;
  logic                 div_by_zero;
  logic                 overflow;

  int n_cmp;
  int n_err;

  dsp_div_signed_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    dividend = r64[AW-1:0];
    divisor  = r64[BW-1:0];
  endtask

  // Counts falling edges from acceptance until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 3 * LAT) begin
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run_div(input string tag,
                         input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                         input logic signed [AW-1:0] eq, input logic signed [BW-1:0] er,
                         input logic edz, input logic eov);
    int lat;
    @(posedge clk);
    check($sformatf("%s_ready", tag), 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    wait_result(lat);
    check($sformatf("%s_lat", tag), 64'(lat), 64'(LAT));
    check($sformatf("%s_q", tag), 64'(quotient), 64'(eq));
    check($sformatf("%s_r", tag), 64'(remainder), 64'(er));
    check($sformatf("%s_dz", tag), 64'(div_by_zero), 64'(edz));
    check($sformatf("%s_ov", tag), 64'(overflow), 64'(eov));
    @(posedge clk);
    check($sformatf("%s_pulse", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s_hold", tag), 64'(quotient), 64'(eq));
  endtask

  initial begin
    logic signed [AW-1:0] min_a;
    logic signed [AW-1:0] a, eq, b_ext, er_full;
    logic signed [BW-1:0] b, er;
    logic [63:0]          r64;
    longint               recon;
    int                   lat;
    bit                   seen;

    n_cmp    = 0;
    n_err    = 0;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    min_a    = {1'b1, {(AW-1){1'b0}}};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_ov", 64'(overflow), 64'd0);

    run_div("pp", 38'sd100, 18'sd7, 38'sd14, 18'sd2, 1'b0, 1'b0);
    run_div("np", -38'sd100, 18'sd7, -38'sd14, -18'sd2, 1'b0, 1'b0);
    run_div("pn", 38'sd100, -18'sd7, -38'sd14, 18'sd2, 1'b0, 1'b0);
    run_div("nn", -38'sd100, -18'sd7, 38'sd14, -18'sd2, 1'b0, 1'b0);
    run_div("dz", 38'sd12345, 18'sd0, 38'sd0, 18'sd0, 1'b1, 1'b0);
    run_div("ovf", min_a, -18'sd1, min_a, 18'sd0, 1'b0, 1'b1);

    // Abort a divide 10 clocks in; no result may appear and outputs clear.
    @(posedge clk);
    in_valid = 1'b1;
    dividend = 38'sd1000;
    divisor  = 18'sd3;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_ov", 64'(overflow), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);

    // Reset wins over a simultaneous in_valid.
    @(posedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    dividend = 38'sd5;
    divisor  = 18'sd1;
    @(posedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    check("rst_vs_valid_ready", 64'(in_ready), 64'd1);

    // Back-to-back: second operands held on in_valid while the first divide runs.
    @(posedge clk);
    in_valid = 1'b1;
    dividend = 38'sd1000;
    divisor  = 18'sd3;
    @(posedge clk);
    dividend = 38'sd999;
    divisor  = 18'sd3;
    wait_result(lat);
    check("b2b1_lat", 64'(lat), 64'(LAT));
    check("b2b1_q", 64'(quotient), 64'd333);
    check("b2b1_r", 64'(remainder), 64'd1);
    check("b2b1_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    wait_result(lat);
    check("b2b2_lat", 64'(lat), 64'(LAT));
    check("b2b2_q", 64'(quotient), 64'd333);
    check("b2b2_r", 64'(remainder), 64'd0);

    // Random regression against the language's truncating / and %.
    for (int i = 0; i < 32; i++) begin
      r64 = {$urandom, $urandom};
      a   = r64[AW-1:0];
      if ($urandom_range(0, 1) == 0) begin
        r64 = {32'd0, $urandom};
        b   = r64[BW-1:0];
      end else begin
        b = BW'($urandom_range(1, 100));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      if (b == '0) b = 18'sd1;
      if (a == min_a && b == -18'sd1) b = 18'sd3;
      b_ext   = AW'(b);
      eq      = a / b_ext;
      er_full = a % b_ext;
      er      = er_full[BW-1:0];
      run_div($sformatf("rnd%0d", i), a, b, eq, er, 1'b0, 1'b0);
      recon = longint'(quotient) * longint'(b) + longint'(remainder);
      check($sformatf("rnd%0d_recon", i), 64'(recon), 64'(longint'(a)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
